// File: rtl/pio_cmd_responder.sv
// Command responder behind a host PIO pair: two-phase toggle handshake, small
// 64-bit register file, WRITE/READ/ADD single-cycle ops and a 32-step shift-add MUL.
module pio_cmd_responder #(
    parameter int REG_ADDR_W = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [31:0] cmd_word,
    input  logic [31:0] data_lo,
    input  logic [31:0] data_hi,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_status
);

    localparam int DEPTH = 2 ** REG_ADDR_W;

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_MUL   = 8'h04;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t      state;
    logic [7:0]  op_q;
    logic [7:0]  addr_q;
    logic [31:0] dlo_q;
    logic [31:0] dhi_q;
    logic [4:0]  iter;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [63:0] regs [DEPTH];

    logic        ack;
    logic        busy;
    logic        err_flag;
    logic        err_pend;
    logic [7:0]  count;
    logic [7:0]  last_op;

    logic [REG_ADDR_W-1:0] idx;
    logic                  addr_ok;
    logic [63:0]           sum;
    logic [63:0]           acc_next;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_word[30:16];

    always_comb begin
        idx      = addr_q[REG_ADDR_W-1:0];
        addr_ok  = (addr_q >> REG_ADDR_W) == 8'd0;
        sum      = regs[idx] + {dhi_q, dlo_q};
        acc_next = mplier[0] ? acc + mcand : acc;
    end

    assign rsp_status = {ack, busy, err_flag, 5'd0, count, 8'd0, last_op};

    // NOTE: the register file sits inside the async-reset block because every
    // entry must read back as zero after reset; this costs reset fan-out, not a RAM.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state    <= IDLE;
            op_q     <= '0;
            addr_q   <= '0;
            dlo_q    <= '0;
            dhi_q    <= '0;
            iter     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            ack      <= 1'b0;
            busy     <= 1'b0;
            err_flag <= 1'b0;
            err_pend <= 1'b0;
            count    <= '0;
            last_op  <= '0;
            rsp_lo   <= '0;
            rsp_hi   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_word[31] != ack) begin
                        op_q   <= cmd_word[7:0];
                        addr_q <= cmd_word[15:8];
                        dlo_q  <= data_lo;
                        dhi_q  <= data_hi;
                        iter   <= '0;
                        acc    <= '0;
                        mcand  <= {32'd0, data_lo};
                        mplier <= data_hi;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end

                EXEC: begin
                    case (op_q)
                        OP_WRITE: begin
                            if (addr_ok) regs[idx] <= {dhi_q, dlo_q};
                            err_pend <= !addr_ok;
                            state    <= RESP;
                        end
                        OP_READ: begin
                            if (addr_ok) {rsp_hi, rsp_lo} <= regs[idx];
                            err_pend <= !addr_ok;
                            state    <= RESP;
                        end
                        OP_ADD: begin
                            if (addr_ok) begin
                                regs[idx]        <= sum;
                                {rsp_hi, rsp_lo} <= sum;
                            end
                            err_pend <= !addr_ok;
                            state    <= RESP;
                        end
                        OP_MUL: begin
                            // One multiplier bit per cycle; the last step writes acc_next directly.
                            acc    <= acc_next;
                            mcand  <= mcand << 1;
                            mplier <= mplier >> 1;
                            iter   <= iter + 5'd1;
                            if (iter == 5'd31) begin
                                {rsp_hi, rsp_lo} <= acc_next;
                                err_pend         <= 1'b0;
                                state            <= RESP;
                            end
                        end
                        default: begin
                            err_pend <= 1'b1;
                            state    <= RESP;
                        end
                    endcase
                end

                RESP: begin
                    ack      <= ~ack;
                    err_flag <= err_pend;
                    last_op  <= op_q;
                    count    <= count + 8'd1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Scoreboard bench for pio_cmd_responder: a host driver pushes model-predicted
// responses, a monitor pops and compares each time the ack toggles.
module tb_pio_cmd_responder;

    localparam int AW   = 3;
    localparam int NREG = 2 ** AW;

    logic        clk_clk     = 1'b0;
    logic        reset_reset = 1'b1;
    logic [31:0] cmd_word    = '0;
    logic [31:0] data_lo     = '0;
    logic [31:0] data_hi     = '0;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic [31:0] rsp_status;

    pio_cmd_responder #(.REG_ADDR_W(AW)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .cmd_word   (cmd_word),
        .data_lo    (data_lo),
        .data_hi    (data_hi),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_status (rsp_status)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        logic [63:0] rsp;
        bit          err;
        int          count;
        logic [7:0]  op;
        bit          ack;
        int          ack_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    // Reference model state: what the host should observe.
    logic [63:0] m_regs [NREG];
    logic [63:0] m_rsp;
    int          m_count;
    bit          m_ack;
    bit          host_req;

    bit          prev_ack;
    logic [63:0] prev_rsp;
    int          busy_run;

    always @(posedge clk_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_rsp    = '0;
        m_count  = 0;
        m_ack    = 1'b0;
        host_req = 1'b0;
    endtask

    // Monitor: every ack toggle must match the oldest outstanding prediction.
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            prev_ack = rsp_status[31];
            prev_rsp = {rsp_hi, rsp_lo};
            busy_run = 0;
        end else begin
            if (rsp_status[31] !== prev_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack: ack toggled to %0b with no command outstanding (cycle %0d)",
                             rsp_status[31], cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_value",      rsp_status[31], mon_e.ack);
                    check("rsp",            {rsp_hi, rsp_lo}, mon_e.rsp);
                    check("rsp_before_ack", prev_rsp, mon_e.rsp);
                    check("error",          rsp_status[29], mon_e.err);
                    check("count",          rsp_status[23:16], mon_e.count[7:0]);
                    check("last_op",        rsp_status[7:0], mon_e.op);
                    check("busy_at_ack",    rsp_status[30], 0);
                    check("reserved_bits",  {rsp_status[28:24], rsp_status[15:8]}, 0);
                    check("ack_latency",    cyc, mon_e.ack_cyc);
                    check("busy_cycles",    busy_run, mon_e.lat);
                end
                busy_run = 0;
            end else if (rsp_status[30]) begin
                busy_run++;
            end
            prev_ack = rsp_status[31];
            prev_rsp = {rsp_hi, rsp_lo};
        end
    end

    task automatic start_cmd(input logic [7:0] op, input logic [7:0] addr,
                             input logic [31:0] lo, input logic [31:0] hi, input bit junk);
        exp_t        e;
        logic [63:0] s;
        @(negedge clk_clk);
        host_req = ~host_req;
        cmd_word = {host_req, junk ? 15'($urandom) : 15'd0, addr, op};
        data_lo  = lo;
        data_hi  = hi;
        e.err    = 1'b0;
        case (op)
            8'h01: if (addr < NREG) m_regs[addr] = {hi, lo}; else e.err = 1'b1;
            8'h02: if (addr < NREG) m_rsp = m_regs[addr]; else e.err = 1'b1;
            8'h03: begin
                if (addr < NREG) begin
                    s            = m_regs[addr] + {hi, lo};
                    m_regs[addr] = s;
                    m_rsp        = s;
                end else begin
                    e.err = 1'b1;
                end
            end
            8'h04:   m_rsp = 64'(lo) * 64'(hi);
            default: e.err = 1'b1;
        endcase
        m_count   = (m_count + 1) % 256;
        m_ack     = ~m_ack;
        e.rsp     = m_rsp;
        e.count   = m_count;
        e.op      = op;
        e.ack     = m_ack;
        e.lat     = (op == 8'h04) ? 33 : 2;
        e.ack_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
    endtask

    // Wait for the outstanding command to be acknowledged, wiggling inputs meanwhile.
    task automatic wait_done(input bit scramble);
        int n;
        n = 0;
        @(negedge clk_clk);
        while (sb.size() != 0 && n < 200) begin
            if (scramble) begin
                cmd_word[30:0] = 31'($urandom);
                data_lo        = $urandom;
                data_hi        = $urandom;
            end
            @(negedge clk_clk);
            n++;
        end
        check("drain_outstanding", sb.size(), 0);
        sb.delete();
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] addr,
                         input logic [31:0] lo, input logic [31:0] hi);
        start_cmd(op, addr, lo, hi, 1'b0);
        wait_done(1'b1);
    endtask

    initial begin
        logic [7:0] rop;
        int         pick;
        int         count0;
        bit         ack0;

        model_reset();
        repeat (3) @(negedge clk_clk);
        check("reset_rsp_lo",     rsp_lo, 0);
        check("reset_rsp_hi",     rsp_hi, 0);
        check("reset_rsp_status", rsp_status, 0);
        reset_reset = 1'b0;
        repeat (2) @(negedge clk_clk);
        check("idle_status", rsp_status, 0);

        // WRITE then READ of the same register.
        issue(8'h01, 8'h03, 32'hDEAD_BEEF, 32'h0123_4567);
        issue(8'h02, 8'h03, 32'h0, 32'h0);
        check("wr_rd_hi",    rsp_hi, 32'h0123_4567);
        check("wr_rd_lo",    rsp_lo, 32'hDEAD_BEEF);
        check("wr_rd_ack",   rsp_status[31], 0);
        check("wr_rd_count", rsp_status[23:16], 2);
        check("wr_rd_err",   rsp_status[29], 0);

        // ADD with 64-bit wraparound.
        issue(8'h01, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(8'h03, 8'h00, 32'h0000_0002, 32'h0);
        check("add_wrap_rsp", {rsp_hi, rsp_lo}, 64'h1);
        issue(8'h02, 8'h00, 32'h0, 32'h0);
        check("add_wrap_reg", {rsp_hi, rsp_lo}, 64'h1);

        // MUL of the largest operands; inputs are scrambled throughout EXEC.
        issue(8'h04, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_hi", rsp_hi, 32'hFFFF_FFFE);
        check("mul_lo", rsp_lo, 32'h0000_0001);

        // Error cases leave the response untouched; a good READ clears the flag.
        issue(8'h07, 8'h00, 32'h1111_1111, 32'h2222_2222);
        check("err_opcode_flag", rsp_status[29], 1);
        check("err_opcode_rsp",  {rsp_hi, rsp_lo}, 64'hFFFF_FFFE_0000_0001);
        issue(8'h01, 8'h08, 32'h3333_3333, 32'h4444_4444);
        check("err_addr_flag", rsp_status[29], 1);
        issue(8'h02, 8'h08, 32'h0, 32'h0);
        issue(8'h03, 8'h09, 32'h5, 32'h0);
        issue(8'h00, 8'h01, 32'h5, 32'h0);
        issue(8'h02, 8'h03, 32'h0, 32'h0);
        check("err_cleared", rsp_status[29], 0);
        check("err_read_lo", rsp_lo, 32'hDEAD_BEEF);

        // Randomized mix against the model.
        for (int k = 0; k < 80; k++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 2)      rop = 8'h01;
            else if (pick <= 4) rop = 8'h02;
            else if (pick <= 6) rop = 8'h03;
            else if (pick == 7) rop = 8'h04;
            else                rop = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
            start_cmd(rop, 8'($urandom_range(0, 9)), $urandom, $urandom, 1'b1);
            wait_done(1'b1);
        end

        // Reset in the middle of a MUL aborts it without an ack.
        start_cmd(8'h04, 8'h00, $urandom, $urandom, 1'b1);
        repeat (10) @(negedge clk_clk);
        reset_reset = 1'b1;
        cmd_word    = '0;
        data_lo     = '0;
        data_hi     = '0;
        sb.delete();
        model_reset();
        @(negedge clk_clk);
        check("midreset_rsp_lo",     rsp_lo, 0);
        check("midreset_rsp_hi",     rsp_hi, 0);
        check("midreset_rsp_status", rsp_status, 0);
        repeat (2) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);
        check("post_reset_idle", rsp_status, 0);
        issue(8'h01, 8'h05, 32'hCAFE_F00D, 32'h0BAD_CAFE);
        check("post_reset_count", rsp_status[23:16], 1);
        check("post_reset_ack",   rsp_status[31], 1);
        issue(8'h02, 8'h03, 32'h0, 32'h0);
        check("post_reset_reg_cleared", {rsp_hi, rsp_lo}, 0);

        // 256 back-to-back READs wrap the count and return the ack to its start value.
        count0 = m_count;
        ack0   = m_ack;
        for (int k = 0; k < 256; k++) begin
            start_cmd(8'h02, 8'($urandom_range(0, NREG - 1)), $urandom, $urandom, 1'b1);
            wait_done(1'b0);
        end
        check("wrap_count", rsp_status[23:16], count0[7:0]);
        check("wrap_ack",   rsp_status[31], ack0);

        repeat (5) @(negedge clk_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_cmd_responder.md
PIO_CMD_RESPONDER -- requirements
Module: pio_cmd_responder

Interface
REQ-001 Parameter REG_ADDR_W, default 3: register-file address width; the file holds 2**REG_ADDR_W 64-bit entries.
REQ-002 clk_clk  input  1  single system clock; all state is clocked on its rising edge.
REQ-003 reset_reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_word  input  32  command from host PIO output: [31] request toggle, [15:8] address, [7:0] opcode; other bits ignored.
REQ-005 data_lo  input  32  operand low word, from host PIO output.
REQ-006 data_hi  input  32  operand high word, from host PIO output.
REQ-007 rsp_lo  output  32  result low word, to host PIO input.
REQ-008 rsp_hi  output  32  result high word, to host PIO input.
REQ-009 rsp_status  output  32  status word: [31] ack toggle, [30] busy, [29] error, [23:16] completed-command count, [7:0] last opcode; other bits 0.

Function
REQ-010 Handshake is two-phase: a request is pending when cmd_word[31] != rsp_status[31] while state is IDLE.
REQ-011 State machine: IDLE, EXEC, RESP; reset enters IDLE.
REQ-012 IDLE -> EXEC on the edge where a request is pending; that edge captures opcode, address, data_lo and data_hi; an iteration counter loads 0.
REQ-013 Inputs are ignored in EXEC and RESP; captured operands govern the whole command.
REQ-014 Opcode 0x01 WRITE: reg[addr] <= {data_hi,data_lo}; rsp_lo/rsp_hi unchanged.
REQ-015 Opcode 0x02 READ: {rsp_hi,rsp_lo} <= reg[addr].
REQ-016 Opcode 0x03 ADD: sum = reg[addr] + {data_hi,data_lo} mod 2**64; the sum is written to both reg[addr] and {rsp_hi,rsp_lo}; carry-out is discarded.
REQ-017 Opcode 0x04 MUL: {rsp_hi,rsp_lo} <= data_lo * data_hi, unsigned 64-bit; computed by shift-add over exactly 32 EXEC cycles; register file untouched.
REQ-018 Single-cycle opcodes (01, 02, 03, illegal) spend exactly 1 cycle in EXEC.
REQ-019 An address >= 2**REG_ADDR_W with opcode 01/02/03 is an error: no register or response write.
REQ-020 Any opcode other than 01..04 is an error: no register or response write.
REQ-021 rsp_status[29] is set by an errored command and cleared by a successful one; it is updated on the RESP edge.
REQ-022 EXEC -> RESP when the operation completes; RESP -> IDLE after 1 cycle.
REQ-023 On the RESP edge: ack toggle inverts; opcode field loads the captured opcode; count increments, wrapping 255 -> 0.
REQ-024 Errored commands are still acknowledged and counted.
REQ-025 Latency from capture edge C to the ack toggle edge: C+2 for single-cycle ops; C+33 for MUL.
REQ-026 rsp_lo/rsp_hi change only on the EXEC completion edge, one cycle before the ack toggles, so results are stable whenever the host sees the ack.
REQ-027 busy (rsp_status[30]) = 1 in EXEC and RESP; 0 in IDLE.
REQ-028 A second host toggle before the ack makes req == ack after the ack; no new command starts (defined, not an error).
REQ-029 A request pending on the same edge RESP -> IDLE is evaluated in IDLE on the next edge.

Reset
REQ-030 While reset_reset = 1, all outputs and all register-file entries are 0, and the state and iteration counter are cleared.
REQ-031 Reset mid-command aborts it with no ack toggle and no register write; the next request after reset release is detected normally.

Verification
REQ-032 WRITE then READ: cmd 0x8000_0301, lo=0xDEAD_BEEF, hi=0x0123_4567, then cmd 0x0000_0302 -> rsp_hi=0x0123_4567, rsp_lo=0xDEAD_BEEF, ack=0, count=2, error=0.
REQ-033 ADD wrap: reg[0]=0xFFFF_FFFF_FFFF_FFFF, ADD operand 0x2 -> rsp=0x0000_0000_0000_0001, reg[0] holds 1, ack at C+2.
REQ-034 MUL: lo=0xFFFF_FFFF, hi=0xFFFF_FFFF -> rsp_hi=0xFFFF_FFFE, rsp_lo=0x0000_0001; busy for 33 cycles; ack at C+33; operand changes during EXEC have no effect.
REQ-035 Errors: opcode 0x07 or address 0x08 -> error=1, rsp unchanged, ack toggles; a following valid READ -> error=0.
REQ-036 Reset asserted at MUL cycle 10 -> all outputs 0, no ack; release, then WRITE -> completes with count=1.
REQ-037 256 back-to-back READs -> count wraps to 0, ack returns to its initial value, no lost or duplicated commands.
